// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream input, restart control and instruction-memory write port of the boot loader.
// Latency: none, this is wiring only.
// Backpressure: the rx_valid/rx_ready pair carries it; the memory port has no backpressure.
interface rom_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    // Byte source / boot supervisor side.
    modport master (
        output rx_valid, rx_data, restart,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_data, restart,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: assembles a framed byte stream into 32-bit words, writes them to instruction memory, releases the core on a good checksum.
// Latency: a word is written the cycle after its 4th byte; done/error/rx_ready update the cycle after the deciding byte.
// Backpressure: rx_ready is high in LEN0..CSUM and low in DONE/ERR until restart; rx_valid gaps only advance the idle timeout.
module rom_loader #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset,
    rom_loader_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;     // 16 bits so N=DEPTH cannot wrap before CSUM
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;         // low three bytes of the word being assembled
    logic [7:0]        r_xor;
    logic [TMO_W-1:0]  r_tmo;

    logic              r_rx_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic [15:0]       w_len_full;
    logic              w_tmo_hit;
    logic              w_last_word;
    logic              w_rearm;

    assign w_accept    = bus.rx_valid & r_rx_ready;
    assign w_len_full  = {bus.rx_data, r_len[7:0]};
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_last_word = (r_byte_idx == 2'd3) && (r_word_cnt == (r_len - 16'd1));
    assign w_rearm     = bus.restart && ((r_state == S_DONE) || (r_state == S_ERR));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accepted bytes walk the frame, an idle run of TIMEOUT cycles mid-frame aborts it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN0: begin
                if (w_accept) w_state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (w_len_full == 16'd0)               w_state_nxt = S_CSUM;
                    else if (w_len_full > 16'(DEPTH))      w_state_nxt = S_ERR;
                    else                                   w_state_nxt = S_DATA;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (w_last_word) w_state_nxt = S_CSUM;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (bus.rx_data == r_xor) ? S_DONE : S_ERR;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (bus.restart) w_state_nxt = S_LEN0;
            end
            default: w_state_nxt = S_LEN0;
        endcase
    end

    // Datapath and registered outputs; status outputs follow the next state so they settle one cycle after the deciding byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_xor       <= '0;
            r_tmo       <= '0;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_rx_ready <= (w_state_nxt == S_LEN0) || (w_state_nxt == S_LEN1) ||
                          (w_state_nxt == S_DATA) || (w_state_nxt == S_CSUM);
            r_cpu_hold <= (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
            r_error    <= (w_state_nxt == S_ERR);

            // The idle counter only runs while a frame is in flight.
            if (w_accept || (r_state == S_LEN0) || (r_state == S_DONE) || (r_state == S_ERR)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_rearm) begin
                r_xor      <= '0;
                r_byte_idx <= '0;
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_xor <= r_xor ^ bus.rx_data;
                case (r_state)
                    S_LEN0: r_len[7:0]  <= bus.rx_data;
                    S_LEN1: r_len[15:8] <= bus.rx_data;
                    S_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                                r_mem_wdata <= {bus.rx_data, r_word};
                                r_word_cnt  <= r_word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized frames checked against a frame-level reference model.
// Latency: expects status one cycle after the deciding byte and writes one cycle after each 4th data byte.
// Backpressure: drives rx_valid with random gaps and waits (bounded) on rx_ready.
module tb_rom_loader;
    localparam int DEPTH   = 1024;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   dbl_we;
    bit   prev_we;

    logic [7:0]  frm[$];
    logic [31:0] exp_w[$];
    wr_t         wr_q[$];
    bit          exp_done;

    rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: records every memory write and counts back-to-back strobes.
    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back(wr_t'{bus.mem_addr, bus.mem_wdata});
        if (bus.mem_we && prev_we) dbl_we++;
        prev_we = bus.mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: decodes a complete frame into its expected words and verdict.
    function automatic void model();
        int          n;
        logic [7:0]  x;
        exp_w.delete();
        n = int'({frm[1], frm[0]});
        if (n > DEPTH) begin
            exp_done = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_w.push_back({frm[2+4*i+3], frm[2+4*i+2], frm[2+4*i+1], frm[2+4*i]});
        x = 8'h00;
        for (int i = 0; i < 2 + 4*n; i++) x ^= frm[i];
        exp_done = (frm[2+4*n] == x);
    endfunction

    // Random frame of n words; flip != 0 corrupts the checksum.
    task automatic build(input int n, input logic [7:0] flip);
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] n16;
        n16 = 16'(n);
        frm.delete();
        frm.push_back(n16[7:0]);
        frm.push_back(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) frm.push_back(w[8*b +: 8]);
        end
        x = 8'h00;
        foreach (frm[i]) x ^= frm[i];
        frm.push_back(x ^ flip);
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit rs);
        int waited;
        waited = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        bus.restart  = rs;
        while (!bus.rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.restart  = 1'b0;
        if (waited >= 50) chk("rx_ready_wait", 64'(waited), 0);
    endtask

    task automatic run_frame(input string tag, input int max_gap, input int rs_at);
        wr_q.delete();
        model();
        foreach (frm[i]) send_byte(frm[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap), (i == rs_at));
        chk({tag, "_done"},     bus.done,     exp_done);
        chk({tag, "_error"},    bus.error,    !exp_done);
        chk({tag, "_cpu_hold"}, bus.cpu_hold, !exp_done);
        chk({tag, "_rx_ready"}, bus.rx_ready, 0);
        chk({tag, "_nwrites"},  wr_q.size(),  exp_w.size());
        for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_q[i].a, i);
            chk($sformatf("%s_data%0d", tag, i), wr_q[i].d, exp_w[i]);
        end
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        chk("restart_cpu_hold", bus.cpu_hold, 1);
        chk("restart_rx_ready", bus.rx_ready, 1);
        chk("restart_flags", {bus.done, bus.error}, 0);
    endtask

    initial begin
        int idle;
        total = 0;
        bad = 0;
        dbl_we = 0;
        prev_we = 1'b0;
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.restart = 1'b0;

        // Reset values, then rx_ready rising on the first edge after release.
        repeat (3) @(negedge clk);
        chk("rst_ctl", {bus.rx_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error}, 5'b00100);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        chk("rdy_before_edge", bus.rx_ready, 0);
        @(negedge clk);
        chk("rdy_after_edge", bus.rx_ready, 1);
        repeat (30) @(negedge clk);
        chk("len0_no_timeout", bus.error, 0);

        // Single-word frame; the XOR of 01 00 13 05 A0 00 is B7.
        frm = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        run_frame("n1_good", 0, -1);
        chk("n1_good_word", bus.mem_wdata, 32'h00A00513);
        do_restart();

        frm = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        run_frame("n1_badcsum", 0, -1);
        do_restart();
        frm = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        run_frame("n1_retry", 0, -1);
        do_restart();

        // Empty frame and oversize length.
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame("n0", 0, -1);
        do_restart();
        frm = '{8'h01, 8'h04};
        run_frame("n1025", 0, -1);
        do_restart();

        // Idle timeout mid-data.
        wr_q.delete();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        idle = 0;
        while (!bus.error && idle < 100) begin
            @(negedge clk);
            idle++;
        end
        chk("timeout_cycles", idle, TIMEOUT);
        chk("timeout_nwrites", wr_q.size(), 0);
        chk("timeout_cpu_hold", bus.cpu_hold, 1);
        do_restart();

        // Random gapped frames; restart mid-frame and restart together with CSUM are both ignored.
        build(2, 8'h00);
        run_frame("n2_gaps", 5, -1);
        do_restart();
        build(3, 8'h00);
        run_frame("rs_midframe", 4, 5);
        do_restart();
        build(2, 8'h00);
        run_frame("rs_with_csum", 3, 10);
        do_restart();
        build($urandom_range(1, 6), 8'h5A);
        run_frame("rand_bad", 5, -1);
        do_restart();

        // Largest legal frame.
        build(DEPTH, 8'h00);
        run_frame("n_depth", 0, -1);
        do_restart();

        // Reset mid-word aborts without writing the partial word.
        wr_q.delete();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {bus.rx_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error}, 5'b00100);
        chk("midrst_addr", bus.mem_addr, 0);
        chk("midrst_wdata", bus.mem_wdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_nwrites", wr_q.size(), 0);
        build(2, 8'h00);
        run_frame("after_rst", 2, -1);

        chk("no_back_to_back_we", dbl_we, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
